// File: rtl/pkt_tcp_csum_arbiter.sv
// pkt_tcp_csum_arbiter: round-robin sharing of one TCP checksum engine with guard gap and stall watchdog
module pkt_tcp_csum_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  output logic [NUM_REQ-1:0]     o_grant,
  input  logic [NUM_REQ-1:0]     i_data_valid,
  input  logic [NUM_REQ*134-1:0] i_data,
  output logic                   o_data_valid,
  output logic [133:0]           o_data,
  output logic                   o_busy,
  output logic [15:0]            o_abort_cnt
);
  localparam int W  = 134;
  localparam int PW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  localparam logic [W-1:0] FORCED = {2'b11, 132'h0};
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state_q;
  logic [PW-1:0] ptr_q, sel, ptr_nxt;
  logic [NUM_REQ-1:0] grant_q;
  logic dv_q;
  logic [W-1:0] data_q, word;
  logic [GW-1:0] gap_q;
  logic [WW-1:0] wd_q;
  logic [15:0] abort_q;
  logic acc, trl, expire;
  int idx;
  // first requester at or after the rr pointer, scanning with wrap; lowest offset wins
  always_comb begin
    sel = ptr_q;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (i_req[idx[PW-1:0]]) sel = idx[PW-1:0];
    end
  end
  // owner's word; only the granted lane can ever reach the engine
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_REQ; k++) if (grant_q[k]) word = i_data[k*W +: W];
  end
  assign ptr_nxt = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign acc     = |(i_data_valid & grant_q);
  assign trl     = acc && (word[W-1:W-2] == 2'b11);
  assign expire  = !acc && (wd_q == WW'(TIMEOUT - 1));
  // arbitration FSM with registered grant, forwarded data, gap and watchdog counters
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      abort_q <= '0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: if (|i_req) begin
          grant_q <= ONE << sel;
          ptr_q   <= ptr_nxt;
          wd_q    <= '0;
          state_q <= XFER;
        end
        XFER: begin
          dv_q <= acc || expire;
          wd_q <= acc ? '0 : wd_q + 1'b1;
          if (acc) data_q <= word;
          if (trl || expire) begin
            grant_q <= '0;
            gap_q   <= GW'(GAP_CYCLES);
            state_q <= GAP;
          end
          if (expire) begin
            data_q  <= FORCED;
            abort_q <= abort_q + {15'd0, ~&abort_q};
          end
        end
        default: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q == GW'(1)) state_q <= IDLE;
        end
      endcase
    end
  assign o_grant      = grant_q;
  assign o_data_valid = dv_q;
  assign o_data       = data_q;
  assign o_busy       = (state_q != IDLE);
  assign o_abort_cnt  = abort_q;
endmodule
